play_seq_ctrl: RTL

PLAY_SEQ_CTRL -- requirements
Module: play_seq_ctrl

---
 rtl/play_seq_pkg.sv | 23 ++
 rtl/play_seq_ctrl_addr_gen.sv | 33 +++
 rtl/play_seq_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/play_seq_pkg.sv
// Shared types and constants for the playback sequencer.
// Optional abort feature is enabled by defining PLAY_SEQ_ABORT_EN.
package play_seq_pkg;

    localparam int          ADDR_W_DEF = 9;
    localparam int          DATA_W_DEF = 12;
    localparam int          CNT_W      = 4;
    localparam int unsigned END_MARK   = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CHECK = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // A requested pass count of zero still plays the table once.
    function automatic logic [CNT_W-1:0] pass_init(input logic [CNT_W-1:0] loop_cnt);
        return (loop_cnt == 4'd0) ? 4'd1 : loop_cnt;
    endfunction

endpackage

// File: rtl/play_seq_ctrl_addr_gen.sv
// ROM address register with clear, increment and last-address flag.
module play_addr_gen
    import play_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;

    // Address register: clear has priority over increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr <= '0;
        end else if (i_clr) begin
            r_addr <= '0;
        end else if (i_inc) begin
            r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            r_addr <= r_addr;
        end
    end

    assign o_addr = r_addr;
    assign o_last = &r_addr;

endmodule

// File: rtl/play_seq_ctrl.sv
// Playback sequencer: streams ROM words until an end marker or the last
// address, repeating for the requested number of passes.
// Define PLAY_SEQ_ABORT_EN to add the abort input.
module play_seq_ctrl
    import play_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [CNT_W-1:0]  loop_cnt,
`ifdef PLAY_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_pass_cnt;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_abort;
    logic              w_addr_clr;
    logic              w_addr_inc;
    logic              w_addr_last;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_clr;
    logic              w_ov_set;
    logic              w_ov_clr;
    logic              w_done_set;
    logic              w_pass_end;

`ifdef PLAY_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    play_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk    (clk),
        .rstn   (rstn),
        .i_clr  (w_addr_clr),
        .i_inc  (w_addr_inc),
        .o_addr (rom_addr),
        .o_last (w_addr_last)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control decode; abort outranks every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_clr  = 1'b0;
        w_addr_inc  = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_ov_set    = 1'b0;
        w_ov_clr    = 1'b0;
        w_done_set  = 1'b0;
        w_pass_end  = 1'b0;
        if (w_abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_addr_clr  = 1'b1;
            w_ov_clr    = 1'b1;
            w_cnt_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_FETCH;
                        w_addr_clr  = 1'b1;
                        w_cnt_load  = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    w_state_nxt = ST_CHECK;
                end
                ST_CHECK: begin
                    if (rom_data == DATA_W'(END_MARK)) begin
                        w_pass_end = 1'b1;
                    end else begin
                        w_ov_set    = 1'b1;
                        w_state_nxt = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        w_ov_clr = 1'b1;
                        if (w_addr_last) begin
                            w_pass_end = 1'b1;
                        end else begin
                            w_addr_inc  = 1'b1;
                            w_state_nxt = ST_FETCH;
                        end
                    end else begin
                        w_state_nxt = ST_OUT;
                    end
                end
                ST_DONE: begin
                    w_done_set  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
            // A pass ends on the marker or after the last address transfers.
            if (w_pass_end) begin
                w_cnt_dec = 1'b1;
                if (r_pass_cnt > 4'd1) begin
                    w_addr_clr  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end else begin
                w_cnt_dec = 1'b0;
            end
        end
    end

    // Registered outputs and pass counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass_cnt  <= '0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= w_done_set;
            if (w_ov_set) begin
                r_out_valid <= 1'b1;
                r_out_data  <= rom_data;
            end else if (w_ov_clr) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
            if (w_cnt_load) begin
                r_pass_cnt <= pass_init(loop_cnt);
            end else if (w_cnt_clr) begin
                r_pass_cnt <= '0;
            end else if (w_cnt_dec) begin
                r_pass_cnt <= r_pass_cnt - 4'd1;
            end else begin
                r_pass_cnt <= r_pass_cnt;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
